// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types, constants and helper functions for the SHA-256
// compression engine. The configuration macro SHA256_COMPRESS_UNROLL2_EN
// (used in sha256_compress.sv) does not affect anything in this package.
package sha256_pkg;

    typedef logic [31:0]       word_t;
    // Working variables / digest words; index 0 (a or H0) sits in the MSBs.
    typedef logic [0:7][31:0]  hstate_t;
    // Message schedule window; index 0 (W_t) sits in the MSBs.
    typedef logic [0:15][31:0] window_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_e;

    localparam hstate_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// sha256_compress_if: block-in / digest-out handshake between a hashing
// wrapper (master) and the compression engine (slave).
interface sha256_compress_if;
    logic         new_hash;
    logic [511:0] in;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] out;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output new_hash, in, in_valid, out_ready,
        input  in_ready, out, out_valid
    );

    modport slave (
        input  new_hash, in, in_valid, out_ready,
        output in_ready, out, out_valid
    );
endinterface

// File: rtl/sha256_round.sv
// sha256_round: one purely combinational SHA-256 round on a..h.
module sha256_round
    import sha256_pkg::*;
(
    input  hstate_t st_i,
    input  word_t   k_i,
    input  word_t   w_i,
    output hstate_t st_o
);
    word_t t1;
    word_t t2;

    assign t1 = st_i[7] + big_sigma1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + k_i + w_i;
    assign t2 = big_sigma0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);

    assign st_o = {t1 + t2, st_i[0], st_i[1], st_i[2],
                   st_i[3] + t1, st_i[4], st_i[5], st_i[6]};
endmodule

// File: rtl/sha256_compress.sv
// sha256_compress: SHA-256 compression engine, one 512-bit block per accept,
// digest held on the bus until consumed. Defining SHA256_COMPRESS_UNROLL2_EN
// performs two chained rounds per cycle (32 ROUND cycles instead of 64).
module sha256_compress
    import sha256_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    sha256_compress_if.slave  bus
);
`ifdef SHA256_COMPRESS_UNROLL2_EN
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = 6;
`endif
    localparam logic [CNT_W-1:0] T_LAST = '1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  t_q, t_d;
    hstate_t           h_q, h_d;
    hstate_t           s_q, s_d;
    window_t           w_q, w_d;

    hstate_t           s_next;
    window_t           w_next;

`ifdef SHA256_COMPRESS_UNROLL2_EN
    hstate_t           s_mid;
    word_t             w_new0, w_new1;

    sha256_round u_round0 (.st_i(s_q),   .k_i(K[{t_q, 1'b0}]), .w_i(w_q[0]), .st_o(s_mid));
    sha256_round u_round1 (.st_i(s_mid), .k_i(K[{t_q, 1'b1}]), .w_i(w_q[1]), .st_o(s_next));

    assign w_new0 = small_sigma1(w_q[14]) + w_q[9]  + small_sigma0(w_q[1]) + w_q[0];
    assign w_new1 = small_sigma1(w_q[15]) + w_q[10] + small_sigma0(w_q[2]) + w_q[1];
    assign w_next = {w_q[2:15], w_new0, w_new1};
`else
    word_t             w_new;

    sha256_round u_round0 (.st_i(s_q), .k_i(K[t_q]), .w_i(w_q[0]), .st_o(s_next));

    assign w_new  = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
    assign w_next = {w_q[1:15], w_new};
`endif

    // FSM state register with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // FSM next-state logic.
    // NOTE: every output of a comb block is defaulted first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid) state_d = S_ROUND;
            S_ROUND: if (t_q == T_LAST) state_d = S_FINAL;
            S_FINAL: state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshake flags decoded from the state.
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
    end

    // Datapath next-state: load on accept, run rounds, fold into H at FINAL.
    always_comb begin
        h_d = h_q;
        s_d = s_q;
        w_d = w_q;
        t_d = t_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_d = bus.in;
                    t_d = '0;
                    if (bus.new_hash) begin
                        h_d = IV;
                        s_d = IV;
                    end else begin
                        s_d = h_q;
                    end
                end
            end
            S_ROUND: begin
                s_d = s_next;
                w_d = w_next;
                t_d = t_q + CNT_W'(1);
            end
            S_FINAL: begin
                for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + s_q[i];
            end
            default: ;
        endcase
    end

    // Digest register and round counter; reset restores IV so no partial digest is seen.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            h_q <= IV;
            t_q <= '0;
        end else begin
            h_q <= h_d;
            t_q <= t_d;
        end
    end

    // Working variables and schedule window.
    // NOTE: these are fully reloaded on every accept, so they carry no reset.
    always_ff @(posedge clk_i) begin
        s_q <= s_d;
        w_q <= w_d;
    end

    assign bus.out = h_q;
endmodule

// File: doc/sha256_compress.md
# sha256_compress

SHA-256 compression engine that answers the block-level hash interface driven by the multi-chunk hashing wrappers in the PBKDF2 datapath. It accepts one 512-bit message block per handshake, runs 64 rounds against the chaining state (either the FIPS 180-4 initial value or the previous digest), and presents the 256-bit digest until it is consumed. Message padding and block sequencing are the initiator's job; this block only compresses.

## Interface
- No parameters.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; synchronous and active-low.
- new_hash  in  1  sampled only at block accept; 1 = start from IV, 0 = chain from current digest.
- in  in  512  message block, big-endian: in[511:480] = W0 … in[31:0] = W15.
- in_valid  in  1  block offered.
- in_ready  out  1  engine can accept a block.
- out  out  256  digest H0..H7, with H0 in out[255:224].
- out_valid  out  1  digest complete and held.
- out_ready  in  1  digest consumed.

## Operation
- States are IDLE, ROUND, FINAL and DONE.
- IDLE:
  - in_ready = 1.
  - Block accepted when in_valid & in_ready.
  - On accept: the 16-word W window loads from in.
  - On accept: a..h load from IV if new_hash = 1, else from the H register. H itself is also set to IV when new_hash = 1.
  - Round counter t is cleared. Go to ROUND.
- ROUND:
  - Each cycle performs round t using K[t] and W_t = window[0].
  - The window shifts left by one word.
  - The new word σ1(w[14]) + w[9] + σ0(w[1]) + w[0] (mod 2^32) is appended.
  - t increments; after t = 63, go to FINAL.
- FINAL: Hi ← Hi + {a..h}i, mod 2^32 per word. Go to DONE.
- DONE:
  - out_valid = 1.
  - When out_ready = 1, go to IDLE.
- in_ready = 0 outside IDLE. in_valid in any other state is ignored and does not queue.
- out_ready outside DONE is ignored.
- out is driven directly from the H register:
  - It changes only at reset, at accept with new_hash = 1, and at FINAL.
  - It is stable through DONE and the following IDLE, so the initiator may chain immediately.
- All arithmetic is 32-bit unsigned, wrapping. Ch, Maj, Σ0, Σ1, σ0 and σ1 follow FIPS 180-4.

## Timing
- Reset (rst_ni = 0 at a clock edge) puts the block in IDLE with:
  - H = IV (out = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
  - out_valid = 0 and t = 0.
  - in_ready = 1 from the first cycle with rst_ni = 1.
- Reset mid-operation (ROUND, FINAL or DONE) aborts the block; no partial digest is ever visible.
- Latency: accept edge E0 → rounds at E1..E64 → FINAL at E65 → out_valid = 1 in the cycle after E65, i.e. 66 cycles after accept.
- Throughput is one block per 67 cycles minimum (DONE for one cycle with out_ready = 1, then IDLE accept).
- Backpressure: out_valid remains 1 and out remains stable for as long as out_ready = 0.

## Configuration
- Macro: SHA256_COMPRESS_UNROLL2_EN.
- Defined:
  - Two chained rounds per cycle using K[2k] and K[2k+1].
  - The window shifts by two words and two schedule words are generated.
  - The counter runs 0..31, so ROUND lasts 32 cycles and out_valid rises 34 cycles after accept.
- Undefined: one round per cycle, 66-cycle latency.
- Interface and digest values are identical either way.

## Structure
- sha256_pkg holds:
  - The K[0:63] constant array and the IV constant.
  - The state enum.
  - Functions Ch, Maj, Σ0, Σ1, σ0 and σ1.
- Sub-module sha256_round: purely combinational single round, taking a..h, K_t and W_t and producing the next a..h. It is instantiated once, or twice in series under SHA256_COMPRESS_UNROLL2_EN.

## Test plan
- "abc": block 61626380, then thirteen zero words, then 00000000 00000018, with new_hash = 1 → out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with out_valid exactly 66 cycles (34 with macro) after accept.
- Empty message: block 80000000 followed by zeros, new_hash = 1 → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Block 1 with new_hash = 1, consume the digest, then block 2 with new_hash = 0.
  - Required result: 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Backpressure: hold out_ready = 0 for 20 cycles in DONE while in_valid = 1 → out_valid stays 1, out stays constant, in_ready stays 0, and no block is accepted.
- Reset mid-hash: assert rst_ni = 0 for one cycle at round 30 → out_valid = 0 and out = IV. A following "abc" block then yields the correct digest.
- Chaining from reset: after reset, send "abc" with new_hash = 0 → same digest as with new_hash = 1, since H = IV after reset.
